// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module  : game_pkg
// Brief   : Shared state encoding and constants for the maze game controller.
// Revision: 1.0
// ============================================================================
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ARM  = 3'd1,
        ST_PLAY = 3'd2,
        ST_WIN  = 3'd3,
        ST_LOSE = 3'd4
    } game_state_t;

    localparam logic [7:0] START_KEY = 8'd40;
    localparam int         TILE_SIZE = 16;

endpackage
`default_nettype wire

// File: rtl/frame_tick_sync.sv
`default_nettype none
// ============================================================================
// Module  : frame_tick_sync
// Brief   : Brings the vsync strobe into the Clk domain; one-Clk tick per rise.
// Revision: 1.0
// ============================================================================
module frame_tick_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic i_frame_clk,
    output logic o_frame_tick
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync2_d;

    // Third flop only remembers the previous synchronised level for edge detect
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sync2_d    <= 1'b0;
            o_frame_tick <= 1'b0;
        end else begin
            r_sync1      <= i_frame_clk;
            r_sync2      <= r_sync1;
            r_sync2_d    <= r_sync2;
            o_frame_tick <= r_sync2 & ~r_sync2_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/maze_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : maze_game_ctrl
// Brief   : Game sequencing FSM: idle, arm countdown, timed play, win/lose.
// Revision: 1.0
// ============================================================================
module maze_game_ctrl
    import game_pkg::game_state_t, game_pkg::ST_IDLE, game_pkg::ST_ARM,
           game_pkg::ST_PLAY, game_pkg::ST_WIN, game_pkg::ST_LOSE;
#(
    parameter logic [5:0] GOAL_X     = 6'd38,
    parameter logic [5:0] GOAL_Y     = 6'd18,
    parameter logic [9:0] TIME_LIMIT = 10'd900,
    parameter logic [7:0] ARM_FRAMES = 8'd60,
    parameter logic [7:0] START_KEY  = game_pkg::START_KEY
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] Keycode,
    input  logic [5:0] ball_x,
    input  logic [5:0] ball_y,
    output logic       game_ready,
    output logic       ball_reset,
    output logic [2:0] game_state,
    output logic [9:0] time_left,
    output logic       win,
    output logic       lose
);

    game_state_t r_state;
    game_state_t w_next_state;
    logic [7:0]  r_key_prev;
    logic [7:0]  r_arm_cnt;
    logic        w_frame_tick;
    logic        w_start_press;
    logic        w_goal;
    logic        w_load;
    logic        w_game_ready_d;
    logic        w_win_d;
    logic        w_lose_d;

    frame_tick_sync u_frame_tick_sync (
        .Clk          (Clk),
        .Reset        (Reset),
        .i_frame_clk  (frame_clk),
        .o_frame_tick (w_frame_tick)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_key_prev <= 8'd0;
        end else begin
            r_key_prev <= Keycode;
        end
    end

    assign w_start_press = (Keycode == START_KEY) && (r_key_prev != START_KEY);
    assign w_goal        = (ball_x == GOAL_X) && (ball_y == GOAL_Y);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Goal is checked ahead of the timeout so a simultaneous finish counts as a win
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE, ST_WIN, ST_LOSE: begin
                if (w_start_press) begin
                    w_next_state = ST_ARM;
                    w_load       = 1'b1;
                end
            end
            ST_ARM: begin
                if (w_frame_tick && (r_arm_cnt <= 8'd1)) begin
                    w_next_state = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (w_goal) begin
                    w_next_state = ST_WIN;
                end else if (w_frame_tick && (time_left <= 10'd1)) begin
                    w_next_state = ST_LOSE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        w_game_ready_d = (w_next_state == ST_PLAY);
        w_win_d        = (w_next_state == ST_WIN);
        w_lose_d       = (w_next_state == ST_LOSE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            game_ready <= 1'b0;
            ball_reset <= 1'b0;
            win        <= 1'b0;
            lose       <= 1'b0;
        end else begin
            game_ready <= w_game_ready_d;
            ball_reset <= w_load;
            win        <= w_win_d;
            lose       <= w_lose_d;
        end
    end

    assign game_state = r_state;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_arm_cnt <= 8'd0;
        end else if (w_load) begin
            r_arm_cnt <= ARM_FRAMES;
        end else if ((r_state == ST_ARM) && w_frame_tick && (r_arm_cnt != 8'd0)) begin
            r_arm_cnt <= r_arm_cnt - 8'd1;
        end
    end

    // A zero limit leaves the counter at its reset value of zero
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            time_left <= TIME_LIMIT;
        end else if (w_load) begin
            if (TIME_LIMIT != 10'd0) begin
                time_left <= TIME_LIMIT;
            end
        end else if ((r_state == ST_PLAY) && w_frame_tick && !w_goal
                     && (time_left != 10'd0)) begin
            time_left <= time_left - 10'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_maze_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_maze_game_ctrl
// Brief   : Scoreboard bench: three controller configurations on shared stimulus.
// Revision: 1.0
// ============================================================================
module tb_maze_game_ctrl;

    typedef struct {
        int    sel;
        string name;
        int    st;
        int    rdy;
        int    w;
        int    l;
        int    tl;
        int    pr;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [7:0] Keycode;
    logic [5:0] ball_x;
    logic [5:0] ball_y;

    logic       rdy   [3];
    logic       brst  [3];
    logic [2:0] st    [3];
    logic [9:0] tl    [3];
    logic       winf  [3];
    logic       losef [3];

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   pulses [3] = '{0, 0, 0};
    logic prev_br [3] = '{1'b0, 1'b0, 1'b0};

    always #5 Clk = ~Clk;

    // 0: defaults, 1: short game, 2: zero time limit
    maze_game_ctrl dut_d (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Keycode(Keycode),
        .ball_x(ball_x), .ball_y(ball_y), .game_ready(rdy[0]), .ball_reset(brst[0]),
        .game_state(st[0]), .time_left(tl[0]), .win(winf[0]), .lose(losef[0])
    );
    maze_game_ctrl #(.TIME_LIMIT(10'd5), .ARM_FRAMES(8'd2)) dut_s (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Keycode(Keycode),
        .ball_x(ball_x), .ball_y(ball_y), .game_ready(rdy[1]), .ball_reset(brst[1]),
        .game_state(st[1]), .time_left(tl[1]), .win(winf[1]), .lose(losef[1])
    );
    maze_game_ctrl #(.TIME_LIMIT(10'd0), .ARM_FRAMES(8'd1)) dut_z (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .Keycode(Keycode),
        .ball_x(ball_x), .ball_y(ball_y), .game_ready(rdy[2]), .ball_reset(brst[2]),
        .game_state(st[2]), .time_left(tl[2]), .win(winf[2]), .lose(losef[2])
    );

    function automatic bit miss(int e, int a);
        return (e != -1) && (e != a);
    endfunction

    // Monitor: count ball_reset pulses, check pulse width, pop and compare
    always @(negedge Clk) begin
        for (int i = 0; i < 3; i++) begin
            if (prev_br[i]) begin
                n_vec++;
                if (brst[i]) begin
                    n_err++;
                    $display("FAIL ball_reset_width dut%0d: high for 2+ cycles, required 1", i);
                end
            end
            if (brst[i]) pulses[i]++;
            prev_br[i] = brst[i];
        end
        if (q.size() != 0) begin
            exp_t e;
            int   s;
            e = q.pop_front();
            s = e.sel;
            n_vec++;
            if (miss(e.st, int'(st[s])) || miss(e.rdy, int'(rdy[s])) ||
                miss(e.w, int'(winf[s])) || miss(e.l, int'(losef[s])) ||
                miss(e.tl, int'(tl[s])) || miss(e.pr, pulses[s])) begin
                n_err++;
                $display("FAIL %s dut%0d: got st=%0d rdy=%0d win=%0d lose=%0d tl=%0d pulses=%0d; want st=%0d rdy=%0d win=%0d lose=%0d tl=%0d pulses=%0d (-1=any)",
                         e.name, s, st[s], rdy[s], winf[s], losef[s], tl[s], pulses[s],
                         e.st, e.rdy, e.w, e.l, e.tl, e.pr);
            end
        end
    end

    task automatic push_exp(int sel, string name, int est, int erdy, int ew, int el,
                            int etl, int epr);
        exp_t e;
        e.sel = sel; e.name = name; e.st = est; e.rdy = erdy;
        e.w = ew; e.l = el; e.tl = etl; e.pr = epr;
        q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge Clk);
            #1;
            n++;
        end
        if (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations never compared, required 0", q.size());
            q.delete();
        end
    endtask

    task automatic step(int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic frame();
        @(posedge Clk);
        #1 frame_clk = 1'b1;
        repeat (4) @(posedge Clk);
        #1 frame_clk = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
    endtask

    task automatic frames(int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; frame_clk = 1'b0; Keycode = 8'd0; ball_x = 6'd0; ball_y = 6'd0;
        step(3);
        push_exp(0, "reset_d", 0, 0, 0, 0, 900, 0);
        push_exp(1, "reset_s", 0, 0, 0, 0, 5, 0);
        push_exp(2, "reset_z", 0, 0, 0, 0, 0, 0);
        drain();
        Reset = 1'b0;
        step(2);

        Keycode = 8'd40;
        step(10);
        push_exp(0, "held_start", 1, 0, 0, 0, 900, 1);
        push_exp(1, "held_start_s", 1, 0, 0, 0, 5, 1);
        drain();
        Keycode = 8'd0;

        frame();
        push_exp(2, "zero_limit_play", 2, 1, 0, 0, 0, -1);
        drain();
        frame();
        push_exp(1, "short_play", 2, 1, 0, 0, 5, -1);
        push_exp(2, "zero_limit_lose", 4, 0, 0, 1, 0, -1);
        drain();
        frames(4);
        push_exp(1, "short_tl1", 2, 1, 0, 0, 1, -1);
        drain();
        frame();
        push_exp(1, "timeout_lose", 4, 0, 0, 1, 0, -1);
        drain();

        frames(52);
        push_exp(0, "arm_59", 1, 0, 0, 0, 900, 1);
        drain();
        frame();
        push_exp(0, "arm_60_play", 2, 1, 0, 0, 900, 1);
        drain();
        frames(3);
        push_exp(0, "play_dec", 2, 1, 0, 0, 897, 1);
        drain();

        ball_x = 6'd38; ball_y = 6'd18;
        step(1);
        push_exp(0, "goal_win", 3, 0, 1, 0, 897, 1);
        drain();
        frame();
        push_exp(0, "win_freeze", 3, 0, 1, 0, 897, 1);
        drain();
        ball_x = 6'd0; ball_y = 6'd0;

        step(1);
        Keycode = 8'd40;
        step(3);
        push_exp(1, "restart_from_lose", 1, 0, 0, 0, 5, 2);
        push_exp(0, "restart_from_win", 1, 0, 0, 0, 900, 2);
        drain();
        Keycode = 8'd0;

        frames(6);
        push_exp(1, "short_tl1_again", 2, 1, 0, 0, 1, -1);
        drain();
        // Goal arrives on the same Clk as the final frame tick
        @(posedge Clk);
        #1 frame_clk = 1'b1;
        repeat (3) @(posedge Clk);
        #1 ball_x = 6'd38; ball_y = 6'd18;
        @(posedge Clk);
        #1 frame_clk = 1'b0;
        push_exp(1, "goal_beats_timeout", 3, 0, 1, 0, -1, -1);
        drain();
        ball_x = 6'd0; ball_y = 6'd0;
        step(4);

        frames(53);
        push_exp(0, "replay", 2, 1, 0, 0, 900, 2);
        drain();
        frame();
        Keycode = 8'd40;
        step(2);
        push_exp(0, "start_ignored_in_play", 2, 1, 0, 0, 899, 2);
        drain();
        step(1);
        Reset = 1'b1;
        push_exp(0, "reset_mid_play", 0, 0, 0, 0, 900, 2);
        drain();
        step(2);
        Reset = 1'b0;
        step(2);
        push_exp(0, "held_key_after_reset", 1, 0, 0, 0, 900, 3);
        drain();
        Keycode = 8'd0;
        step(3);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
